// File: rtl/prio_encoder_148.sv
// 74x148-style priority encoder with input synchronizers and a valid/ready handshake.
// Define PRIO_ENC_LATCH_EN to latch request edges into pending bits; default is level mode.
module prio_encoder_148 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei_n,
    input  logic [7:0] I,
    output logic [2:0] A,
    output logic       valid,
    input  logic       ready,
    output logic       gs_n,
    output logic       eo_n,
    output logic [7:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OFFER = 2'b01,
        ACK   = 2'b10
    } state_t;

    state_t     state, state_next;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] req;
    logic [7:0] pending;
    logic [2:0] top_idx;
    logic       load;

    // I is asynchronous: nothing but the first synchronizer flop may see it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= ~I;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign req = sync_q[SYNC_STAGES-1];

`ifdef PRIO_ENC_LATCH_EN
    logic [7:0] req_prev;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] lost;
    logic [3:0] lost_cnt;
    logic [8:0] miss_sum;
    logic       accept;

    assign accept = (state == OFFER) && ready;

    // a new edge on a bit being cleared this cycle re-arms it rather than counting as a miss
    always_comb begin
        rise     = req & ~req_prev;
        clr      = accept ? (8'b1 << A) : '0;
        lost     = rise & pending & ~clr;
        lost_cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lost_cnt = lost_cnt + 4'(lost[i]);
        end
        miss_sum = {1'b0, miss_cnt} + 9'(lost_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev <= '0;
            pending  <= '0;
            miss_cnt <= '0;
        end else begin
            req_prev <= req;
            pending  <= (pending & ~clr) | rise;
            miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end
`else
    assign pending  = req;
    assign miss_cnt = '0;
`endif

    always_comb begin
        top_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!ei_n && (pending != '0)) begin
                    state_next = OFFER;
                    load       = 1'b1;
                end
            end
            OFFER:   state_next = ready ? ACK : OFFER;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A     <= '0;
            valid <= 1'b0;
            gs_n  <= 1'b1;
            eo_n  <= 1'b1;
        end else begin
            state <= state_next;
            if (load) begin
                A <= top_idx;
            end
            valid <= (state_next == OFFER);
            gs_n  <= ei_n | ~(|pending);
            eo_n  <= ei_n | (|pending);
        end
    end

endmodule

// File: doc/prio_encoder_148.md
PRIO_ENCODER_148 -- requirements
Module: prio_encoder_148

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, number of synchronizer flops on I (legal values 2..4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ei_n  input  1  enable input, active-low (74x148 EI); synchronous to clk.
REQ-005 SHALL have port: I  input  8  request lines, active-low, asynchronous; I[7] highest priority.
REQ-006 SHALL have port: A  output  3  registered binary code of granted line (true binary, not inverted).
REQ-007 SHALL have port: valid  output  1  registered; code on A is offered.
REQ-008 SHALL have port: ready  input  1  consumer accepts A when valid and ready are both high at a clock edge.
REQ-009 SHALL have port: gs_n  output  1  registered, low when any pending bit is set and ei_n low.
REQ-010 SHALL have port: eo_n  output  1  registered, low when ei_n low and no pending bit is set.
REQ-011 SHALL have port: miss_cnt  output  8  registered count of requests lost to an already-pending bit.

Function
REQ-012 SHALL invert I and pass it through SYNC_STAGES flops to form req[7:0]; no other logic acts on unsynchronized I.
REQ-013 SHALL hold pending[7:0]; contents as per REQ-027/REQ-028.
REQ-014 SHALL implement FSM states IDLE, OFFER, ACK; encoded in 2 bits; unused encoding returns to IDLE next cycle.
REQ-015 IDLE: valid=0; when ei_n=0 and pending!=0, next state OFFER and A loaded with index of highest set pending bit.
REQ-016 OFFER: valid=1; A and valid held stable until ready=1; ei_n going high does not withdraw the offer.
REQ-017 OFFER with ready=1: next state ACK; pending[A] cleared at that same edge (latch mode).
REQ-018 ACK: valid=0 for exactly one cycle; next state IDLE unconditionally.
REQ-019 SHALL accept at most one code per 3 cycles (OFFER, ACK, IDLE).
REQ-020 Higher-priority request arriving during OFFER SHALL NOT change A; it is offered in a later OFFER.
REQ-021 ei_n=1 in IDLE: remain IDLE; pending continues to collect requests.
REQ-022 gs_n, eo_n SHALL update every cycle from registered pending and ei_n (one-cycle lag); ei_n=1 forces gs_n=1, eo_n=1.
REQ-023 miss_cnt SHALL saturate at 255, never wrap.

Reset
REQ-024 rst_n low SHALL immediately clear synchronizer flops, pending, miss_cnt; state IDLE; A=0, valid=0, gs_n=1, eo_n=1.
REQ-025 Reset asserted during OFFER SHALL drop the offer without any acceptance taking effect.
REQ-026 After rst_n deasserts, first valid not earlier than latency in REQ-027/REQ-028 from a held-low I line.

Configuration
REQ-027 With PRIO_ENC_LATCH_EN defined: pending bit set on rising edge of req (req & ~req_prev), cleared only by acceptance; set and clear of same bit in same cycle -> set wins; edge on already-set bit with no same-cycle clear increments miss_cnt; I low sampled at edge N -> valid=1 after edge N+SYNC_STAGES+1.
REQ-028 Without PRIO_ENC_LATCH_EN: pending equals req (level, combinational); acceptance clears nothing; line held low is re-offered every 3 cycles; miss_cnt tied to 0; I low at edge N -> valid=1 after edge N+SYNC_STAGES.

Verification
REQ-029 Latch mode, SYNC_STAGES=2: pulse I[5] low one cycle at edge 10, ready=1 -> valid=1 after edge 13 with A=5; ACK next; pending=0; gs_n=1, eo_n=0 afterwards.
REQ-030 Latch mode: I[2] and I[6] low together, ready=0 for 5 cycles -> A=6 held stable 5 cycles; then ready=1 -> A=6 accepted, later A=2 offered.
REQ-031 Latch mode: during OFFER A=3 with ready=0, pulse I[3] low twice more -> miss_cnt=2; after acceptance pending[3]=0.
REQ-032 ei_n=1 with I[7] pulsed -> valid stays 0, gs_n=1, eo_n=1; drive ei_n=0 -> valid=1 with A=7 one cycle later.
REQ-033 rst_n low asynchronously mid-OFFER (A=4) -> valid=0, A=0, pending=0, miss_cnt=0 without a clock edge.
REQ-034 Level mode (macro undefined): hold I[1] low, ready=1 -> A=1 accepted every 3 cycles; miss_cnt stays 0.
